fetch_stage_if_id: RTL and testbench
====================================

# fetch_stage_if_id

Instruction-fetch stage for the pipelined MIPS core. It owns the program counter, drives the instruction-memory request, and produces the IF/ID pipeline register. It sits directly upstream of the PC input mux: it feeds `pc_plus_4` into the mux and consumes the mux result as `next_pc` on a taken branch or jump. It honours the hazard unit's load-use stall and flushes IF/ID on redirect, and it tolerates a variable-latency instruction memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `next_pc`, in, 32, redirect target from the PC input mux; used only on a redirect.
- `pc_src_taken`, in, 1, branch/jump/jr taken in ID. Sampled only when `stall`=0.
- `stall`, in, 1, load-use stall from the hazard unit; freezes IF/ID.
- `imem_addr`, out, 32, always equals the PC register.
- `imem_req`, out, 1, fetch request; a function of state only.
- `imem_rdata`, in, 32, instruction word; valid when `imem_ready`=1.
- `imem_ready`, in, 1, the request completes this cycle. May be high in the same cycle as `imem_req`.
- `pc_plus_4`, out, 32, combinational PC+4 mod 2^32.
- `if_id_instr`, out, 32, registered instruction to ID.
- `if_id_pc_plus_4`, out, 32, registered PC+4 of that instruction (for BTA and jal).
- `if_id_valid`, out, 1, 0 when IF/ID holds a bubble.

## Operation
- Protocol: while `imem_req`=1, `imem_addr` stays stable until `imem_ready`=1. Requests are never abandoned.
- Bubble: `if_id_instr`=NOP_INSTR, `if_id_pc_plus_4`=0, `if_id_valid`=0.
- Registers: `pc`, `state`, IF/ID, hold buffer (`hold_instr`, `hold_pc4`), `redir_pc`.
- FETCH state, `imem_req`=1. Priority order:
  - `stall`=1, `imem_ready`=1: hold buffer <= {rdata, pc+4}; pc <= pc+4; go to HELD. IF/ID holds.
  - `stall`=1, `imem_ready`=0: everything holds.
  - `stall`=0, `pc_src_taken`=1: IF/ID <= bubble. If ready, pc <= `next_pc` and stay in FETCH. If not ready, `redir_pc` <= `next_pc` and go to KILL.
  - `stall`=0, `imem_ready`=1: IF/ID <= {rdata, pc+4, 1}; pc <= pc+4.
  - `stall`=0, `imem_ready`=0: IF/ID <= bubble; pc holds.
- HELD state, `imem_req`=0:
  - `stall`=1: hold.
  - `stall`=0 with `pc_src_taken`=1: IF/ID <= bubble; discard the buffer; pc <= `next_pc`; go to FETCH.
  - `stall`=0 otherwise: IF/ID <= {hold_instr, hold_pc4, 1}; go to FETCH.
- KILL state, `imem_req`=1, `imem_addr` = old pc:
  - IF/ID <= bubble when `stall`=0; holds when `stall`=1.
  - `pc_src_taken` is ignored, because ID holds a bubble.
  - On `imem_ready`: discard rdata; pc <= `redir_pc`; go to FETCH.
- Arithmetic: pc+4 is a 32-bit wrapping add. 0xFFFF_FFFC+4 = 0. No alignment checks.

## Timing
- Reset values: pc = RESET_PC; state = FETCH; IF/ID = bubble; hold buffer = 0; `redir_pc` = 0. During and after reset: `imem_req`=1 and `imem_addr`=RESET_PC.
- Reset mid-operation has priority over everything, in any state including KILL with a request outstanding. The memory is reset alongside.
- Latency: instruction at address A appears in IF/ID on the edge that ends the cycle where `imem_addr`=A and `imem_ready`=1.
- Throughput: with zero-wait memory and no hazards, one instruction per cycle.
- Redirect: `next_pc` is presented on `imem_addr` the cycle after the redirect edge (zero-wait memory). The wrong-path instruction never reaches IF/ID with valid=1.
- Stall and redirect in the same cycle: stall wins and `pc_src_taken` is ignored.
- Stall release: the buffered instruction enters IF/ID on the first edge with `stall`=0. There is no extra bubble.
- `pc_plus_4` and `imem_req` are combinational from registers only. There is no input-to-output path.

## Test plan
- Zero-wait run: reset, then `imem_ready`=1 tied high. Required: `imem_addr` 0, 4, 8, 0xC on consecutive cycles. IF/ID trails by one cycle with `if_id_pc_plus_4` 4, 8, 0xC and `if_id_valid`=1.
- Load-use stall: `stall`=1 for 2 cycles while pc=8. Required: IF/ID holds the instruction from address 4. pc becomes 0xC with `imem_req`=0 during HELD. On release, IF/ID receives the instruction from address 8 with pc4=0xC, then 0xC fetch resumes.
- Redirect: at pc=0x10, `pc_src_taken`=1 and `next_pc`=0x40. Required: next cycle `if_id_valid`=0, `if_id_instr`=NOP_INSTR, `imem_addr`=0x40.
- Redirect during wait: at pc=0x20, `imem_ready`=0 for 3 cycles; redirect to 0x100 in the first cycle. Required: `imem_addr`=0x20 until ready, then 0x100. Data from 0x20 never appears with valid=1.
- Wrap: RESET_PC=0xFFFF_FFFC. Required: `pc_plus_4`=0 and the next `imem_addr`=0.
- Reset while in KILL. Required: `imem_addr`=RESET_PC and `if_id_valid`=0 after the reset edge; the stale `redir_pc` is never used.

Source files
------------

// File: rtl/fetch_stage_if_id.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// produces the IF/ID pipeline register, with load-use stall and redirect handling.
module fetch_stage_if_id #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        pc_src_taken,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_plus_4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus_4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HELD  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t      state_r,      state_nxt_s;
    logic [31:0] pc_r,         pc_nxt_s;
    logic [31:0] instr_r,      instr_nxt_s;
    logic [31:0] pc4_r,        pc4_nxt_s;
    logic        valid_r,      valid_nxt_s;
    logic [31:0] hold_instr_r, hold_instr_nxt_s;
    logic [31:0] hold_pc4_r,   hold_pc4_nxt_s;
    logic [31:0] redir_pc_r,   redir_pc_nxt_s;
    logic [31:0] pc4_s;

    assign pc4_s           = pc_r + 32'd4;
    assign pc_plus_4       = pc4_s;
    assign imem_addr       = pc_r;
    assign imem_req        = (state_r != S_HELD);
    assign if_id_instr     = instr_r;
    assign if_id_pc_plus_4 = pc4_r;
    assign if_id_valid     = valid_r;

    // State register update; reset returns to FETCH at RESET_PC with a bubble in IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_FETCH;
            pc_r         <= RESET_PC;
            instr_r      <= NOP_INSTR;
            pc4_r        <= 32'h0000_0000;
            valid_r      <= 1'b0;
            hold_instr_r <= 32'h0000_0000;
            hold_pc4_r   <= 32'h0000_0000;
            redir_pc_r   <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            instr_r      <= instr_nxt_s;
            pc4_r        <= pc4_nxt_s;
            valid_r      <= valid_nxt_s;
            hold_instr_r <= hold_instr_nxt_s;
            hold_pc4_r   <= hold_pc4_nxt_s;
            redir_pc_r   <= redir_pc_nxt_s;
        end
    end

    // Next-state logic: stall outranks redirect; a pending request is never abandoned.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        instr_nxt_s      = instr_r;
        pc4_nxt_s        = pc4_r;
        valid_nxt_s      = valid_r;
        hold_instr_nxt_s = hold_instr_r;
        hold_pc4_nxt_s   = hold_pc4_r;
        redir_pc_nxt_s   = redir_pc_r;

        case (state_r)
            S_FETCH: begin
                if (stall) begin
                    if (imem_ready) begin
                        hold_instr_nxt_s = imem_rdata;
                        hold_pc4_nxt_s   = pc4_s;
                        pc_nxt_s         = pc4_s;
                        state_nxt_s      = S_HELD;
                    end else begin
                        state_nxt_s      = S_FETCH;
                    end
                end else if (pc_src_taken) begin
                    instr_nxt_s = NOP_INSTR;
                    pc4_nxt_s   = 32'h0000_0000;
                    valid_nxt_s = 1'b0;
                    if (imem_ready) begin
                        pc_nxt_s       = next_pc;
                    end else begin
                        // The outstanding fetch must complete before the target is issued.
                        redir_pc_nxt_s = next_pc;
                        state_nxt_s    = S_KILL;
                    end
                end else if (imem_ready) begin
                    instr_nxt_s = imem_rdata;
                    pc4_nxt_s   = pc4_s;
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc4_s;
                end else begin
                    instr_nxt_s = NOP_INSTR;
                    pc4_nxt_s   = 32'h0000_0000;
                    valid_nxt_s = 1'b0;
                end
            end
            S_HELD: begin
                if (stall) begin
                    state_nxt_s = S_HELD;
                end else if (pc_src_taken) begin
                    instr_nxt_s = NOP_INSTR;
                    pc4_nxt_s   = 32'h0000_0000;
                    valid_nxt_s = 1'b0;
                    pc_nxt_s    = next_pc;
                    state_nxt_s = S_FETCH;
                end else begin
                    instr_nxt_s = hold_instr_r;
                    pc4_nxt_s   = hold_pc4_r;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = S_FETCH;
                end
            end
            S_KILL: begin
                if (stall) begin
                    valid_nxt_s = valid_r;
                end else begin
                    instr_nxt_s = NOP_INSTR;
                    pc4_nxt_s   = 32'h0000_0000;
                    valid_nxt_s = 1'b0;
                end
                if (imem_ready) begin
                    pc_nxt_s    = redir_pc_r;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_KILL;
                end
            end
            default: begin
                state_nxt_s = S_FETCH;
                instr_nxt_s = NOP_INSTR;
                pc4_nxt_s   = 32'h0000_0000;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage_if_id.sv
// Directed, table-driven bench for fetch_stage_if_id with a simple instruction
// memory that returns {8'hA5, addr[23:0]} for every address.
module tb_fetch_stage_if_id;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        pc_src_taken;
    logic        stall;
    logic        imem_ready;

    logic [31:0] imem_addr,  imem_rdata,  pc_plus_4,  if_id_instr,  if_id_pc_plus_4;
    logic        imem_req,   if_id_valid;
    logic [31:0] w_imem_addr, w_imem_rdata, w_pc_plus_4, w_if_id_instr, w_if_id_pc_plus_4;
    logic        w_imem_req,  w_if_id_valid;

    int checks_total = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = {8'hA5, imem_addr[23:0]};
    assign w_imem_rdata = {8'hA5, w_imem_addr[23:0]};

    fetch_stage_if_id dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .pc_src_taken(pc_src_taken),
        .stall(stall), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc_plus_4(pc_plus_4),
        .if_id_instr(if_id_instr), .if_id_pc_plus_4(if_id_pc_plus_4),
        .if_id_valid(if_id_valid)
    );

    fetch_stage_if_id #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
        .clk(clk), .reset(reset), .next_pc(next_pc), .pc_src_taken(pc_src_taken),
        .stall(stall), .imem_addr(w_imem_addr), .imem_req(w_imem_req),
        .imem_rdata(w_imem_rdata), .imem_ready(imem_ready), .pc_plus_4(w_pc_plus_4),
        .if_id_instr(w_if_id_instr), .if_id_pc_plus_4(w_if_id_pc_plus_4),
        .if_id_valid(w_if_id_valid)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        tkn;
        logic        rdy;
        logic [31:0] npc;
        logic [31:0] e_addr;
        logic        e_req;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stl, input logic tkn, input logic rdy,
                       input logic [31:0] npc, input logic [31:0] e_addr, input logic e_req,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
        vec_t v;
        v.rst = rst; v.stl = stl; v.tkn = tkn; v.rdy = rdy; v.npc = npc;
        v.e_addr = e_addr; v.e_req = e_req; v.e_instr = e_instr;
        v.e_pc4 = e_pc4; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic tkn, input logic rdy,
                         input logic [31:0] npc);
        reset = rst; stall = stl; pc_src_taken = tkn; imem_ready = rdy; next_pc = npc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  rst   stl   tkn   rdy   next_pc        addr           req   instr          pc4            valid
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        // zero-wait run
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'hA500_0000, 32'h0000_0004, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'hA500_0004, 32'h0000_0008, 1'b1);
        // load-use stall at pc=8 for two cycles, then release
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_000C, 1'b0, 32'hA500_0004, 32'h0000_0008, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_000C, 1'b0, 32'hA500_0004, 32'h0000_0008, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_000C, 1'b1, 32'hA500_0008, 32'h0000_000C, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0010, 1'b1, 32'hA500_000C, 32'h0000_0010, 1'b1);
        // redirect at pc=0x10 to 0x40
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0044, 1'b1, 32'hA500_0040, 32'h0000_0044, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        // redirect during a 3-cycle wait at pc=0x20; later taken is ignored in KILL
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0020, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0020, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0100, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0104, 1'b1, 32'hA500_0100, 32'h0000_0104, 1'b1);
        // stall with memory not ready: everything holds; then a wait bubble
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b1, 32'hA500_0100, 32'h0000_0104, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        // stall and taken together: stall wins
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'h0000_0108, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        // redirect out of HELD discards the buffer
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0300, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0300, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        // reset while in KILL; stale redir_pc must not be used
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'hA500_0000, 32'h0000_0004, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].tkn, vecs[i].rdy, vecs[i].npc);
            check($sformatf("addr[%0d]", i),  imem_addr,              vecs[i].e_addr);
            check($sformatf("req[%0d]", i),   {31'd0, imem_req},      {31'd0, vecs[i].e_req});
            check($sformatf("pc4c[%0d]", i),  pc_plus_4,              vecs[i].e_addr + 32'd4);
            check($sformatf("instr[%0d]", i), if_id_instr,            vecs[i].e_instr);
            check($sformatf("ifpc4[%0d]", i), if_id_pc_plus_4,        vecs[i].e_pc4);
            check($sformatf("valid[%0d]", i), {31'd0, if_id_valid},   {31'd0, vecs[i].e_valid});
        end

        // wrap-around from RESET_PC = 0xFFFF_FFFC
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        check("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc4", w_pc_plus_4, 32'h0000_0000);
        check("wrap_reset_req", {31'd0, w_imem_req}, 32'h0000_0001);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
        check("wrap_next_addr", w_imem_addr, 32'h0000_0000);
        check("wrap_instr", w_if_id_instr, 32'hA5FF_FFFC);
        check("wrap_ifpc4", w_if_id_pc_plus_4, 32'h0000_0000);
        check("wrap_valid", {31'd0, w_if_id_valid}, 32'h0000_0001);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
        check("wrap_addr2", w_imem_addr, 32'h0000_0004);
        check("wrap_instr2", w_if_id_instr, 32'hA500_0000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
